// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcode constants, branch-counter encoding and
// immediate extraction helpers used by fetch pre-decode and by decode.
package rv32_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // 2-bit saturating branch counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    // B-type immediate, sign-extended, bit 0 always zero.
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended, bit 0 always zero.
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Saturating step of a counter towards the resolved outcome.
    function automatic bht_ctr_t ctr_step(input bht_ctr_t c, input logic taken);
        if (taken)
            return (c == ST) ? ST : bht_ctr_t'(c + 2'd1);
        else
            return (c == SNT) ? SNT : bht_ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating counters with a combinational read port and a
// single training port. Counters come out of reset weakly not taken.
module branch_history_table
    import rv32_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_ctr,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_idx,
    input  logic          upd_taken
);

    bht_ctr_t ctr_reg [ENTRIES];

    // Lookup returns the stored value, so a same-cycle update is not visible yet.
    assign rd_ctr = ctr_reg[rd_idx];

    // Train the addressed counter; asynchronous reset restores every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_reg[i] <= WNT;
        end else if (upd_en) begin
            ctr_reg[upd_idx] <= ctr_step(ctr_reg[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, instruction-memory address, and
// next-PC prediction from a pre-decode of the fetched word.
// Define BRANCH_PREDICT_EN to enable the counter table and taken prediction
// for JAL/branches; without it fetch is static not-taken (pc + 4).
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        PCWrite,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        bht_update,
    input  logic [31:0] bht_update_pc,
    input  logic        bht_update_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        predicted_out
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        taken;

    assign pc_plus4 = pc_reg + 32'd4;

`ifdef BRANCH_PREDICT_EN
    localparam int IW = $clog2(BHT_ENTRIES);

    logic [1:0] ctr;
    logic       unused_upd_pc;

    // Only the index bits of the update PC address the table.
    assign unused_upd_pc = ^{bht_update_pc[31:IW+2], bht_update_pc[1:0]};

    branch_history_table #(
        .ENTRIES(BHT_ENTRIES)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc_reg[IW+1:2]),
        .rd_ctr    (ctr),
        .upd_en    (bht_update),
        .upd_idx   (bht_update_pc[IW+1:2]),
        .upd_taken (bht_update_taken)
    );

    // Pre-decode: JAL always taken, conditional branch follows counter MSB.
    always_comb begin
        taken  = 1'b0;
        target = pc_plus4;
        if (imem_data[6:0] == OPC_JAL) begin
            taken  = 1'b1;
            target = pc_reg + imm_j(imem_data);
        end else if (imem_data[6:0] == OPC_BRANCH) begin
            taken  = ctr[1];
            target = pc_reg + imm_b(imem_data);
        end
    end
`else
    logic unused_bht;

    // Static not-taken: training inputs and table size have no effect.
    assign unused_bht = ^{bht_update, bht_update_pc, bht_update_taken, 32'(BHT_ENTRIES)};
    assign taken      = 1'b0;
    assign target     = pc_plus4;
`endif

    assign pc_next = taken ? target : pc_plus4;

    // Redirect beats stall and enable; otherwise advance only when both allow it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc_reg <= RESET_PC;
        else if (redirect_valid)
            pc_reg <= redirect_pc;
        else if (enable && PCWrite)
            pc_reg <= pc_next;
    end

    assign imem_addr     = pc_reg;
    assign pc_out        = pc_reg;
    assign instruction   = imem_data;
    assign predicted_out = taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with a next-PC scoreboard queue.
// Expectations for JAL/branch prediction follow BRANCH_PREDICT_EN.
module tb_fetch_stage;

`ifdef BRANCH_PREDICT_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] JAL_P20 = 32'h0200_006F; // jal x0, +0x20
    localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3; // beq x0, x0, -8
    localparam logic [31:0] J_NEXT  = PE ? 32'h30 : 32'h14;
    localparam logic [31:0] B_NEXT  = PE ? 32'h38 : 32'h44;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        PCWrite = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        bht_update = 1'b0;
    logic [31:0] bht_update_pc = '0;
    logic        bht_update_taken = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        predicted_out;

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .PCWrite          (PCWrite),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .bht_update       (bht_update),
        .bht_update_pc    (bht_update_pc),
        .bht_update_taken (bht_update_taken),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .instruction      (instruction),
        .pc_out           (pc_out),
        .predicted_out    (predicted_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tb_mem(input logic [31:0] a);
        case (a)
            32'h10:  return JAL_P20;
            32'h40:  return BEQ_M8;
            default: return NOP;
        endcase
    endfunction

    assign imem_data = tb_mem(imem_addr);

    typedef struct {
        logic [31:0] cur_pc;
        logic        rv;
        logic [31:0] rpc;
        logic        en;
        logic        pw;
        logic        upd;
        logic [31:0] upd_pc;
        logic        upd_tk;
        logic        exp_pred;
        logic [31:0] exp_next;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] cur, input logic rv, input logic [31:0] rpc,
                                input logic en, input logic pw, input logic upd,
                                input logic [31:0] upc, input logic utk,
                                input logic pred, input logic [31:0] nxt);
        vec_t v;
        v.cur_pc = cur; v.rv = rv; v.rpc = rpc; v.en = en; v.pw = pw;
        v.upd = upd; v.upd_pc = upc; v.upd_tk = utk;
        v.exp_pred = pred; v.exp_next = nxt;
        return v;
    endfunction

    // Drive one cycle, check the combinational fetch outputs, then the new PC.
    task automatic apply(input vec_t v, input int idx);
        logic [31:0] e;
        @(negedge clk);
        redirect_valid   = v.rv;
        redirect_pc      = v.rpc;
        enable           = v.en;
        PCWrite          = v.pw;
        bht_update       = v.upd;
        bht_update_pc    = v.upd_pc;
        bht_update_taken = v.upd_tk;
        #1;
        check($sformatf("v%0d pc_out", idx), pc_out, v.cur_pc);
        check($sformatf("v%0d instruction", idx), instruction, tb_mem(v.cur_pc));
        check($sformatf("v%0d predicted_out", idx), 32'(predicted_out), 32'(v.exp_pred));
        exp_q.push_back(v.exp_next);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("v%0d next imem_addr", idx), imem_addr, e);
        $display("vec %0d: pc=%h pred=%0d -> next=%h", idx, v.cur_pc, predicted_out, imem_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          cur           rv rpc           en pw upd upc    tk pred nxt
        vecs.push_back(mk(32'h0,        0, 32'h0,        1, 1, 0, 32'h0,  0, 0,  32'h4));
        vecs.push_back(mk(32'h4,        0, 32'h0,        1, 1, 0, 32'h0,  0, 0,  32'h8));
        vecs.push_back(mk(32'h8,        0, 32'h0,        1, 1, 0, 32'h0,  0, 0,  32'hC));
        vecs.push_back(mk(32'hC,        1, 32'h8,        1, 1, 0, 32'h0,  0, 0,  32'h8));
        vecs.push_back(mk(32'h8,        0, 32'h0,        1, 0, 0, 32'h0,  0, 0,  32'h8));
        vecs.push_back(mk(32'h8,        0, 32'h0,        1, 0, 0, 32'h0,  0, 0,  32'h8));
        vecs.push_back(mk(32'h8,        0, 32'h0,        0, 1, 0, 32'h0,  0, 0,  32'h8));
        vecs.push_back(mk(32'h8,        1, 32'h100,      1, 0, 0, 32'h0,  0, 0,  32'h100));
        vecs.push_back(mk(32'h100,      1, 32'h10,       0, 1, 0, 32'h0,  0, 0,  32'h10));
        vecs.push_back(mk(32'h10,       0, 32'h0,        1, 1, 0, 32'h0,  0, PE, J_NEXT));
        vecs.push_back(mk(J_NEXT,       1, 32'h40,       1, 1, 0, 32'h0,  0, 0,  32'h40));
        // same-cycle update: lookup still sees WNT
        vecs.push_back(mk(32'h40,       0, 32'h0,        1, 0, 1, 32'h40, 1, 0,  32'h40));
        vecs.push_back(mk(32'h40,       0, 32'h0,        1, 0, 0, 32'h0,  0, PE, 32'h40));
        vecs.push_back(mk(32'h40,       0, 32'h0,        1, 1, 0, 32'h0,  0, PE, B_NEXT));
        // four more taken updates, then two not-taken
        vecs.push_back(mk(B_NEXT,       1, 32'h40,       1, 1, 1, 32'h40, 1, 0,  32'h40));
        vecs.push_back(mk(32'h40,       0, 32'h0,        1, 0, 1, 32'h40, 1, PE, 32'h40));
        vecs.push_back(mk(32'h40,       0, 32'h0,        1, 0, 1, 32'h40, 1, PE, 32'h40));
        vecs.push_back(mk(32'h40,       0, 32'h0,        1, 0, 1, 32'h40, 1, PE, 32'h40));
        vecs.push_back(mk(32'h40,       0, 32'h0,        1, 0, 1, 32'h40, 0, PE, 32'h40));
        vecs.push_back(mk(32'h40,       0, 32'h0,        1, 0, 1, 32'h40, 0, PE, 32'h40));
        vecs.push_back(mk(32'h40,       0, 32'h0,        1, 1, 0, 32'h0,  0, 0,  32'h44));
        // wrap-around
        vecs.push_back(mk(32'h44,       1, 32'hFFFF_FFFC, 1, 1, 0, 32'h0, 0, 0,  32'hFFFF_FFFC));
        vecs.push_back(mk(32'hFFFF_FFFC, 0, 32'h0,       1, 1, 0, 32'h0,  0, 0,  32'h0));

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset imem_addr", imem_addr, 32'h0);
        check("reset pc_out", pc_out, 32'h0);
        check("reset predicted_out", 32'(predicted_out), 32'h0);
        $display("reset: pc=%h pred=%0d", pc_out, predicted_out);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // train index 0x40 to WT, then assert reset mid-cycle
        apply(mk(32'h0,  1, 32'h40, 1, 1, 1, 32'h40, 1, 0,  32'h40), 100);
        apply(mk(32'h40, 0, 32'h0,  1, 0, 0, 32'h0,  0, PE, 32'h40), 101);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async reset pc_out", pc_out, 32'h0);
        check("async reset imem_addr", imem_addr, 32'h0);
        $display("async reset: pc=%h", pc_out);
        @(posedge clk);
        #1;
        check("reset held pc_out", pc_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        // counters back to WNT: branch at 0x40 predicts not taken
        apply(mk(32'h0,  1, 32'h40, 1, 1, 0, 32'h0, 0, 0, 32'h40), 102);
        apply(mk(32'h40, 0, 32'h0,  1, 1, 0, 32'h0, 0, 0, 32'h44), 103);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
